// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: clears a single-port sync RAM after reset, then serves one read/write at a time with optional write verify
module ram_access_ctrl #(
  parameter int AW = 2,
  parameter int DW = 2,
  parameter int VERIFY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          init_done_o,
  output logic          err_sticky_o,
  output logic [7:0]    err_cnt_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);
  typedef enum logic [2:0] {INIT, IDLE, WR, VRD, VCHK, RD, RCAP, RESP} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          sticky_q, sticky_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic          mis;
  // state and datapath registers; reset restarts the sweep and drops any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      ecnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      ecnt_q      <= ecnt_d;
    end
  end
  assign mis = ram_dout_i != wdata_q;
  // next-state and register updates per state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    ecnt_d      = ecnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: if (req_valid_i) begin
        we_d    = req_we_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        state_d = req_we_i ? WR : RD;
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = (VERIFY != 0) ? VRD : RESP;
      end
      VRD: state_d = VCHK;
      VCHK: begin
        err_d    = mis;
        sticky_d = sticky_q | mis;
        ecnt_d   = ecnt_q + {7'd0, mis && ecnt_q != 8'hff};
        state_d  = RESP;
      end
      RD: begin
        err_d   = 1'b0;
        state_d = RCAP;
      end
      RCAP: begin
        rdata_d = ram_dout_i;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  assign req_ready_o  = state_q == IDLE;
  assign rsp_valid_o  = state_q == RESP;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign init_done_o  = init_done_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = ecnt_q;
  assign ram_we_o     = state_q == INIT || state_q == WR;
  assign ram_addr_o   = state_q == INIT ? cnt_q : addr_q;
  assign ram_din_o    = state_q == WR ? wdata_q : '0;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed checks of clear sweep, read/write timing, verify errors, reset abort and no-verify throughput
module tb_ram_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic       a_init_done, a_err_sticky, a_ram_we, a_stuck;
  logic [1:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_ram_addr, a_ram_din, a_ram_dout;
  logic [7:0] a_err_cnt;
  logic [1:0] a_mem [4];
  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic       b_init_done, b_err_sticky, b_ram_we;
  logic [1:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_ram_addr, b_ram_din, b_ram_dout;
  logic [7:0] b_err_cnt;
  logic [1:0] b_mem [4];
  ram_access_ctrl #(.AW(2), .DW(2), .VERIFY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
    .init_done_o(a_init_done), .err_sticky_o(a_err_sticky), .err_cnt_o(a_err_cnt),
    .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr), .ram_din_o(a_ram_din), .ram_dout_i(a_ram_dout)
  );
  ram_access_ctrl #(.AW(2), .DW(2), .VERIFY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .init_done_o(b_init_done), .err_sticky_o(b_err_sticky), .err_cnt_o(b_err_cnt),
    .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr), .ram_din_o(b_ram_din), .ram_dout_i(b_ram_dout)
  );
  // single-port RAM models with registered read; a_stuck forces bit 0 of stored data to 0
  always @(posedge clk) begin
    if (a_ram_we) a_mem[a_ram_addr] <= a_stuck ? (a_ram_din & 2'b10) : a_ram_din;
    a_ram_dout <= a_mem[a_ram_addr];
    if (b_ram_we) b_mem[b_ram_addr] <= b_ram_din;
    b_ram_dout <= b_mem[b_ram_addr];
  end
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic a_txn(input logic we, input logic [1:0] ad, input logic [1:0] wd,
                       output logic [1:0] rd, output logic er, output int lat);
    a_req_valid = 1'b1;
    a_req_we = we;
    a_req_addr = ad;
    a_req_wdata = wd;
    a_rsp_ready = 1'b1;
    tick;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    rd = a_rsp_rdata;
    er = a_rsp_err;
    tick;
  endtask
  initial begin
    logic [1:0] rd;
    logic       er;
    int         lat, last, n;
    rst = 1'b1;
    a_stuck = 1'b0;
    {a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_rsp_ready} = '0;
    {b_req_valid, b_req_we, b_req_addr, b_req_wdata} = '0;
    b_rsp_ready = 1'b1;
    tick;
    tick;
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_init_done", a_init_done, 0);
    chk("rst_err_cnt", a_err_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_we", a_ram_we, 1);
      chk("sweep_addr", a_ram_addr, i);
      chk("sweep_din", a_ram_din, 0);
      chk("sweep_ready", a_req_ready, 0);
      tick;
    end
    chk("init_done", a_init_done, 1);
    chk("init_ready", a_req_ready, 1);
    chk("idle_we", a_ram_we, 0);
    for (int i = 0; i < 4; i++) begin
      a_txn(1'b0, 2'(i), 2'd0, rd, er, lat);
      chk("clr_rdata", rd, 0);
      chk("clr_lat", lat, 3);
    end
    a_txn(1'b1, 2'd2, 2'd3, rd, er, lat);
    chk("wr_err", er, 0);
    chk("wr_rdata", rd, 0);
    chk("wr_lat", lat, 4);
    a_txn(1'b0, 2'd2, 2'd0, rd, er, lat);
    chk("rd_rdata", rd, 3);
    chk("rd_err", er, 0);
    chk("rd_lat", lat, 3);
    a_req_valid = 1'b1;
    a_req_we = 1'b0;
    a_req_addr = 2'd2;
    a_rsp_ready = 1'b0;
    tick;
    a_req_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", a_rsp_valid, 1);
      chk("hold_rdata", a_rsp_rdata, 3);
      chk("hold_ready", a_req_ready, 0);
      tick;
    end
    a_rsp_ready = 1'b1;
    tick;
    chk("rel_ready", a_req_ready, 1);
    chk("rel_valid", a_rsp_valid, 0);
    chk("rel_rdata_kept", a_rsp_rdata, 3);
    a_stuck = 1'b1;
    a_txn(1'b1, 2'd1, 2'd1, rd, er, lat);
    chk("vfy_err", er, 1);
    chk("vfy_sticky", a_err_sticky, 1);
    chk("vfy_cnt1", a_err_cnt, 1);
    for (int i = 0; i < 299; i++) a_txn(1'b1, 2'd1, 2'd1, rd, er, lat);
    chk("vfy_cnt_sat", a_err_cnt, 255);
    a_txn(1'b1, 2'd1, 2'd2, rd, er, lat);
    chk("vfy_ok_err", er, 0);
    chk("vfy_ok_cnt", a_err_cnt, 255);
    chk("vfy_ok_sticky", a_err_sticky, 1);
    a_stuck = 1'b0;
    a_req_valid = 1'b1;
    a_req_we = 1'b0;
    a_req_addr = 2'd2;
    tick;
    a_req_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("abort_valid", a_rsp_valid, 0);
    chk("abort_ready", a_req_ready, 0);
    chk("abort_init", a_init_done, 0);
    chk("abort_rdata", a_rsp_rdata, 0);
    chk("abort_err", a_rsp_err, 0);
    chk("abort_sticky", a_err_sticky, 0);
    chk("abort_cnt", a_err_cnt, 0);
    chk("abort_we", a_ram_we, 1);
    chk("abort_addr", a_ram_addr, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("resweep_addr", a_ram_addr, i);
      chk("resweep_valid", a_rsp_valid, 0);
      tick;
    end
    chk("resweep_done", a_init_done, 1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("initrst_addr", a_ram_addr, 0);
    chk("initrst_done", a_init_done, 0);
    for (int i = 0; i < 4; i++) tick;
    chk("initrst_ready", a_req_ready, 1);
    a_txn(1'b0, 2'd2, 2'd0, rd, er, lat);
    chk("cleared_rdata", rd, 0);
    last = 0;
    b_req_valid = 1'b1;
    b_req_we = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!b_req_ready && n < 10) begin
        tick;
        n++;
      end
      if (k > 0) chk("b_spacing", cyc - last, 3);
      last = cyc;
      b_req_addr = 2'(k);
      b_req_wdata = 2'(k);
      tick;
    end
    b_req_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("b_err_cnt", b_err_cnt, 0);
    chk("b_sticky", b_err_sticky, 0);
    chk("b_mem0", b_mem[0], 0);
    chk("b_mem1", b_mem[1], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request/response front-end that sits directly upstream of the team's single-port synchronous RAM and owns its `we`/`addr`/`din` pins.
- After every reset it clears the whole array with a write sweep.
- It then serves one read or write request at a time over a valid/ready handshake.
- It captures the RAM's registered read data and can read back every write to check it, flagging mismatches.

## Interface
Parameters:
- AW, 2, RAM address width; depth = 2^AW
- DW, 2, data width
- VERIFY, 1, 1 = read back and compare after every write; 0 = no readback

Ports:
- clk  in  1  clock; rising edge only
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DW  read data; 0 for write responses
- rsp_err  out  1  write-verify mismatch for this response
- init_done  out  1  high once the clear sweep has finished
- err_sticky  out  1  at least one verify mismatch since reset
- err_cnt  out  8  number of mismatches, saturating at 255
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; registered inside the RAM, valid one cycle after the RAM sees an address with we=0

## Operation
- The request fields (`req_we`, `req_addr`, `req_wdata`) are latched on acceptance, i.e. when req_valid && req_ready. `ram_*` outputs are decoded only from the state register, the latched fields and the sweep counter; there is no combinational path from `req_*` to `ram_*`.
- States and transitions:
  - INIT: ram_we=1, ram_addr=cnt, ram_din=0; cnt increments every cycle. After cnt = 2^AW-1: set init_done=1, go to IDLE.
  - IDLE: ram_we=0, ram_addr=last latched addr; req_ready=1. On acceptance go to WR if we=1, otherwise RD.
  - WR: ram_we=1, ram_addr/ram_din = latched values. Next state is VRD if VERIFY=1, else RESP with rsp_err=0.
  - VRD: ram_we=0, ram_addr=latched addr. Go to VCHK.
  - VCHK: compare ram_dout with the latched wdata. On mismatch: rsp_err=1, err_sticky=1, err_cnt+1 (saturates at 255). Go to RESP.
  - RD: ram_we=0, ram_addr=latched addr. Go to RCAP.
  - RCAP: rsp_rdata <= ram_dout. Go to RESP.
  - RESP: rsp_valid=1. When rsp_ready: rsp_valid=0, go to IDLE; rsp_rdata and rsp_err keep their values.
- While in RESP, rsp_rdata and rsp_err do not change.
- In every state except IDLE, req_ready=0 and req_valid is ignored.
- Only one transaction is ever in flight.
- In all non-write states ram_we=0, so the RAM's continuous reads are harmless.
- Reset values: state=INIT, cnt=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_sticky=0, err_cnt=0, latched fields=0. ram_we=1 and ram_addr=0 follow from INIT.
- An rst pulse in any state abandons the current transaction with no response and restarts the sweep at address 0. This includes a pulse during the INIT sweep.
- Request and response handshakes on the same cycle cannot occur, because the states are disjoint.

## Timing
- INIT sweep: exactly 2^AW cycles (4 at defaults). req_ready is first high in the cycle after the last sweep write.
- Read, accepted in IDLE cycle T:
  - RD in T+1
  - RCAP in T+2
  - RESP in T+3 with rsp_valid=1
  - Minimum 4 cycles from one acceptance to the next.
- Write, accepted in cycle T:
  - VERIFY=1: WR T+1, VRD T+2, VCHK T+3, RESP T+4.
  - VERIFY=0: WR T+1, RESP T+2.
- When rsp_ready is already high on entry to RESP, RESP lasts 1 cycle.

## Test plan
- Reset released, then clock 4 cycles: ram_we=1 with ram_addr 0,1,2,3 and ram_din=0; init_done=1 and req_ready=1 from cycle 5. Reading addresses 0–3 returns 0 for each.
- Write addr 2, data 3, then read addr 2: write response has rsp_err=0; read response has rsp_rdata=3, rsp_valid at acceptance+3, rsp_err=0.
- Hold rsp_ready=0 for 5 cycles during a read response: rsp_valid and rsp_rdata stay stable, req_ready stays 0. After rsp_ready rises, req_ready=1 the next cycle.
- Bench RAM model with bit 0 stuck at 0; write data 1: rsp_err=1, err_sticky=1, err_cnt=1. After 300 failing writes, err_cnt=255.
- Assert rst during RCAP of a read: no response is issued, all outputs return to reset values, and the sweep restarts at ram_addr=0.
- VERIFY=0, 10 back-to-back writes with rsp_ready=1: each accepted 3 cycles apart; err_cnt stays 0.
